// File: rtl/median5_stream_if.sv
// Sample-in / median-out handshake bundle for median5_stream.
// master drives samples and takes medians; slave is the filter.
interface median5_stream_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/median5_stream.sv
// Streaming 5-tap sliding-window median filter with a one-entry registered output.
// The median is picked by ranking the incoming sample against the 4 stored samples.
module median5_stream #(
   parameter int WIDTH = 8
) (
   input  logic              clk,
   input  logic              ngreset,
   input  logic              flush,
   output logic [2:0]        fill_level,
   median5_stream_if.slave   bus
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_FILL  = 2'd1,
      ST_RUN   = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [2:0]       r_level;
   logic [2:0]       w_level_nxt;
   logic             w_emit;
   logic             w_accept;
   logic             r_out_valid;
   logic [WIDTH-1:0] r_out_data;
   logic [WIDTH-1:0] r_w0, r_w1, r_w2, r_w3;
   logic [WIDTH-1:0] w_c    [5];
   logic [2:0]       w_rank [5];
   logic [4:0]       w_sel;
   logic [WIDTH-1:0] w_median;

   assign bus.in_ready  = !flush && (!r_out_valid || bus.out_ready);
   assign w_accept      = bus.in_valid && bus.in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.out_data  = r_out_data;
   assign fill_level    = r_level;

   assign w_c[0] = bus.in_data;
   assign w_c[1] = r_w0;
   assign w_c[2] = r_w1;
   assign w_c[3] = r_w2;
   assign w_c[4] = r_w3;

   // Equal values are ordered by candidate index, so exactly one candidate gets rank 2.
   always_comb begin
      // NOTE: every combinationally written signal gets a default first, so no path leaves it unassigned and no latch is inferred.
      w_sel    = '0;
      w_median = '0;
      for (int i = 0; i < 5; i++) begin
         w_rank[i] = 3'd0;
         for (int j = 0; j < 5; j++) begin
            if ((w_c[j] < w_c[i]) || ((j < i) && (w_c[j] == w_c[i]))) begin
               w_rank[i] = w_rank[i] + 3'd1;
            end
         end
         w_sel[i] = (w_rank[i] == 3'd2);
         w_median = w_median | (w_c[i] & {WIDTH{w_sel[i]}});
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_level_nxt = r_level;
      w_emit      = 1'b0;
      if (flush) begin
         w_state_nxt = ST_EMPTY;
         w_level_nxt = 3'd0;
      end else if (w_accept) begin
         unique case (r_state)
            ST_EMPTY: begin
               w_state_nxt = ST_FILL;
               w_level_nxt = 3'd1;
            end
            ST_FILL: begin
               w_level_nxt = r_level + 3'd1;
               if (r_level == 3'd4) begin
                  w_state_nxt = ST_RUN;
                  w_emit      = 1'b1;
               end
            end
            ST_RUN: begin
               w_emit = 1'b1;
            end
            default: begin
               w_state_nxt = ST_EMPTY;
               w_level_nxt = 3'd0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge ngreset) begin
      if (!ngreset) begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         r_state <= ST_EMPTY;
         r_level <= 3'd0;
      end else begin
         r_state <= w_state_nxt;
         r_level <= w_level_nxt;
      end
   end

   always_ff @(posedge clk or negedge ngreset) begin
      if (!ngreset) begin
         r_w0        <= '0;
         r_w1        <= '0;
         r_w2        <= '0;
         r_w3        <= '0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
      end else if (flush) begin
         // out_data is deliberately left alone; only its valid flag drops.
         r_w0        <= '0;
         r_w1        <= '0;
         r_w2        <= '0;
         r_w3        <= '0;
         r_out_valid <= 1'b0;
      end else begin
         if (w_accept) begin
            r_w3 <= r_w2;
            r_w2 <= r_w1;
            r_w1 <= r_w0;
            r_w0 <= bus.in_data;
         end
         if (w_emit) begin
            r_out_data  <= w_median;
            r_out_valid <= 1'b1;
         end else if (bus.out_ready && r_out_valid) begin
            r_out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_median5_stream.sv
// Directed bench for median5_stream: fill, streaming, ties, backpressure, flush, async reset.
module tb_median5_stream;

   logic       clk;
   logic       ngreset;
   logic       flush;
   logic [2:0] fill_level;
   int         total;
   int         bad;

   median5_stream_if #(.WIDTH(8)) bus ();

   median5_stream #(.WIDTH(8)) dut (
      .clk        (clk),
      .ngreset    (ngreset),
      .flush      (flush),
      .fill_level (fill_level),
      .bus        (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Present a sample for one edge, then settle 1 time unit past the edge.
   task automatic push(input logic [7:0] d);
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   initial begin
      total         = 0;
      bad           = 0;
      ngreset       = 1'b0;
      flush         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b1;
      #12;
      check("rst_out_valid", 32'(bus.out_valid), 0);
      check("rst_out_data",  32'(bus.out_data), 0);
      check("rst_fill",      32'(fill_level), 0);
      ngreset = 1'b1;
      @(posedge clk);
      #1;

      // Fill: 10,50,20,40,30
      push(8'd10); check("fill1_valid", 32'(bus.out_valid), 0); check("fill1_level", 32'(fill_level), 1);
      push(8'd50); check("fill2_valid", 32'(bus.out_valid), 0); check("fill2_level", 32'(fill_level), 2);
      push(8'd20); check("fill3_valid", 32'(bus.out_valid), 0); check("fill3_level", 32'(fill_level), 3);
      push(8'd40); check("fill4_valid", 32'(bus.out_valid), 0); check("fill4_level", 32'(fill_level), 4);
      push(8'd30);
      check("fill5_valid", 32'(bus.out_valid), 1);
      check("fill5_data",  32'(bus.out_data), 30);
      check("fill5_level", 32'(fill_level), 5);

      // Impulse rejection
      push(8'd255); check("imp1_valid", 32'(bus.out_valid), 1); check("imp1_data", 32'(bus.out_data), 40);
      push(8'd30);  check("imp2_valid", 32'(bus.out_valid), 1); check("imp2_data", 32'(bus.out_data), 30);
      push(8'd30);  check("imp3_valid", 32'(bus.out_valid), 1); check("imp3_data", 32'(bus.out_data), 30);

      // Ties: 7,7,7,3,9
      push(8'd7);  check("tie1_data", 32'(bus.out_data), 30);
      push(8'd7);  check("tie2_data", 32'(bus.out_data), 30);
      push(8'd7);  check("tie3_data", 32'(bus.out_data), 7);
      push(8'd3);  check("tie4_data", 32'(bus.out_data), 7);
      bus.in_data = 8'd9;
      #1;
      check("tie5_onehot", 32'($countones(dut.w_sel)), 1);
      push(8'd9);  check("tie5_data", 32'(bus.out_data), 7);

      // All zeros
      push(8'd0); check("zero1_data", 32'(bus.out_data), 7);
      push(8'd0); check("zero2_data", 32'(bus.out_data), 3);
      push(8'd0);
      push(8'd0);
      push(8'd0); check("zero5_data", 32'(bus.out_data), 0);

      // Backpressure with out_data=0 pending
      push(8'd60); check("bp_pre1", 32'(bus.out_data), 0);
      push(8'd60); check("bp_pre2", 32'(bus.out_data), 0);
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_data   = 8'd60;
      for (int k = 0; k < 3; k++) begin
         #1;
         check("bp_in_ready", 32'(bus.in_ready), 0);
         @(posedge clk);
         #1;
         check("bp_valid", 32'(bus.out_valid), 1);
         check("bp_data",  32'(bus.out_data), 0);
         check("bp_level", 32'(fill_level), 5);
      end
      bus.out_ready = 1'b1;
      #1;
      check("bp_rel_ready", 32'(bus.in_ready), 1);
      push(8'd60);
      check("bp_rel_valid", 32'(bus.out_valid), 1);
      check("bp_rel_data",  32'(bus.out_data), 60);

      // Flush with in_valid high
      flush        = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_data  = 8'd200;
      #1;
      check("fl_in_ready", 32'(bus.in_ready), 0);
      @(posedge clk);
      #1;
      flush        = 1'b0;
      bus.in_valid = 1'b0;
      check("fl_level", 32'(fill_level), 0);
      check("fl_valid", 32'(bus.out_valid), 0);
      check("fl_data",  32'(bus.out_data), 60);
      push(8'd1); check("fl_a1", 32'(bus.out_valid), 0);
      push(8'd2); check("fl_a2", 32'(bus.out_valid), 0);
      push(8'd3); check("fl_a3", 32'(bus.out_valid), 0);
      push(8'd4); check("fl_a4", 32'(bus.out_valid), 0); check("fl_a4_level", 32'(fill_level), 4);
      push(8'd5);
      check("fl_a5_valid", 32'(bus.out_valid), 1);
      check("fl_a5_data",  32'(bus.out_data), 3);

      // Output taken with no new sample clears out_valid
      @(posedge clk);
      #1;
      check("drain_valid", 32'(bus.out_valid), 0);
      push(8'd6);
      check("post_drain_valid", 32'(bus.out_valid), 1);
      check("post_drain_data",  32'(bus.out_data), 4);

      // Asynchronous reset between edges
      #2;
      ngreset = 1'b0;
      #1;
      check("ar_valid", 32'(bus.out_valid), 0);
      check("ar_data",  32'(bus.out_data), 0);
      check("ar_level", 32'(fill_level), 0);
      @(negedge clk);
      ngreset = 1'b1;
      @(posedge clk);
      #1;
      push(8'd9); check("ar_f1", 32'(bus.out_valid), 0);
      push(8'd8); check("ar_f2", 32'(bus.out_valid), 0);
      push(8'd7); check("ar_f3", 32'(bus.out_valid), 0);
      push(8'd6); check("ar_f4", 32'(bus.out_valid), 0);
      push(8'd5);
      check("ar_f5_valid", 32'(bus.out_valid), 1);
      check("ar_f5_data",  32'(bus.out_data), 7);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
